// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-setup helpers: GCD FSM encoding and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rsa_pkg;

  // Control states of the GCD engine
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_t;

  // Width needed to count RUN cycles up to 2W+1
  function automatic int cycles_width(input int w);
    return $clog2(2 * w + 2);
  endfunction

  // Width of the common power-of-two counter k (k never exceeds W)
  function automatic int kcnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bin_gcd_step.sv
// One binary-GCD (Stein) reduction step on the working operands x, y and shift count k.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to register the next values.
module bin_gcd_step
  import rsa_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = kcnt_width(W)
) (
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  y,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  x_nxt,
  output logic [W-1:0]  y_nxt,
  output logic [KW-1:0] k_nxt,
  output logic          term
);

  logic [W-1:0] diff_xy;
  logic [W-1:0] diff_yx;

  // Both differences are formed; the compare below picks the one that cannot underflow
  assign diff_xy = x - y;
  assign diff_yx = y - x;

  // Priority-ordered reduction; once either operand is zero everything holds
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    k_nxt = k;
    term  = (x == '0) || (y == '0);
    if (!term) begin
      if (!x[0] && !y[0]) begin
        // Common factor of two: remember it in k
        x_nxt = x >> 1;
        y_nxt = y >> 1;
        k_nxt = k + 1'b1;
      end else if (!x[0]) begin
        x_nxt = x >> 1;
      end else if (!y[0]) begin
        y_nxt = y >> 1;
      end else if (x >= y) begin
        // Odd minus odd is even, so the halving is exact
        x_nxt = diff_xy >> 1;
      end else begin
        y_nxt = diff_yx >> 1;
      end
    end
  end

endmodule

// File: rtl/bin_gcd.sv
// Binary GCD engine with start/finish handshake, optional constant-time mode and step count.
// Latency: finish N+1 cycles after accept; N = steps+1 (variable) or 2W+1 (constant-time).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module bin_gcd
  import rsa_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(2 * W + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          ct_mode,
  output logic [W-1:0]  gcd,
  output logic          finish,
  output logic          busy,
  output logic [CW-1:0] cycles
);

  localparam int KW = kcnt_width(W);
  // Constant-time runs leave RUN when the step counter reaches 2W
  localparam logic [CW-1:0] CT_LAST = CW'(2 * W);

  gcd_state_t    state;
  gcd_state_t    state_nxt;

  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [KW-1:0] k;
  logic [CW-1:0] it;
  logic          ct;

  logic [W-1:0]  x_nxt;
  logic [W-1:0]  y_nxt;
  logic [KW-1:0] k_nxt;
  logic          term;
  logic          run_exit;
  logic [W-1:0]  result;

  bin_gcd_step #(
    .W  (W),
    .KW (KW)
  ) u_step (
    .x     (x),
    .y     (y),
    .k     (k),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .k_nxt (k_nxt),
    .term  (term)
  );

  // gcd = (surviving operand) * 2^k; the survivor is whichever of x, y is nonzero
  assign result = (x | y) << k;

  // Variable mode stops at termination; constant-time mode pads to a fixed count
  always_comb begin
    run_exit = ct ? (it == CT_LAST) : term;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (run_exit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy   = (state != ST_IDLE);
    finish = (state == ST_DONE);
  end

  // Operand latch, one reduction step per RUN cycle, result capture on RUN exit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      k      <= '0;
      it     <= '0;
      ct     <= 1'b0;
      gcd    <= '0;
      cycles <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x  <= a;
            y  <= b;
            k  <= '0;
            it <= '0;
            ct <= ct_mode;
          end
        end
        ST_RUN: begin
          // After termination the step block holds x/y/k, so CT padding is harmless
          x  <= x_nxt;
          y  <= y_nxt;
          k  <= k_nxt;
          it <= it + 1'b1;
          if (run_exit) begin
            gcd    <= result;
            cycles <= it + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_gcd.sv
// Self-checking bench for bin_gcd at W=8, 16 and 32.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin_gcd;

  logic clk;
  logic rst_n;

  logic        st8, ct8, fin8, busy8;
  logic [7:0]  a8, b8, g8;
  logic [4:0]  cyc8;
  logic        st16, ct16, fin16, busy16;
  logic [15:0] a16, b16, g16;
  logic [5:0]  cyc16;
  logic        st32, ct32, fin32, busy32;
  logic [31:0] a32, b32, g32;
  logic [6:0]  cyc32;

  int checks = 0;
  int failures = 0;

  int          cur = 0;
  logic [31:0] cur_gcd;
  logic        cur_fin;
  logic        cur_busy;
  int          cur_cyc;

  bin_gcd #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .ct_mode(ct8),
    .gcd(g8), .finish(fin8), .busy(busy8), .cycles(cyc8)
  );
  bin_gcd #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .ct_mode(ct16),
    .gcd(g16), .finish(fin16), .busy(busy16), .cycles(cyc16)
  );
  bin_gcd #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .a(a32), .b(b32), .ct_mode(ct32),
    .gcd(g32), .finish(fin32), .busy(busy32), .cycles(cyc32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Route the outputs of the instance under test
  always_comb begin
    cur_gcd  = '0;
    cur_fin  = 1'b0;
    cur_busy = 1'b0;
    cur_cyc  = 0;
    case (cur)
      0: begin cur_gcd = {24'd0, g8};  cur_fin = fin8;  cur_busy = busy8;  cur_cyc = 32'(cyc8);  end
      1: begin cur_gcd = {16'd0, g16}; cur_fin = fin16; cur_busy = busy16; cur_cyc = 32'(cyc16); end
      default: begin cur_gcd = g32; cur_fin = fin32; cur_busy = busy32; cur_cyc = 32'(cyc32); end
    endcase
  end

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    bit          ct;
    logic [31:0] g;
    int          cyc;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Euclid's algorithm: independent of the shift/subtract method under test
  function automatic longint unsigned ref_gcd(input longint unsigned p, input longint unsigned q);
    longint unsigned t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input logic c);
    case (sel)
      0: begin st8 = s;  a8 = av[7:0];   b8 = bv[7:0];   ct8 = c;  end
      1: begin st16 = s; a16 = av[15:0]; b16 = bv[15:0]; ct16 = c; end
      default: begin st32 = s; a32 = av; b32 = bv; ct32 = c; end
    endcase
  endtask

  // One operation; lat = index of the edge after accept whose cycle carries finish
  task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                        input bit ctm, output logic [31:0] g, output int cyc,
                        output int lat, output bit busy_ok);
    cur = sel;
    @(negedge clk);
    drive(sel, 1'b1, av, bv, ctm);
    @(posedge clk);
    busy_ok = 1'b1;
    lat = -1;
    for (int e = 0; e < 200; e++) begin
      @(negedge clk);
      if (e == 0) drive(sel, 1'b0, av, bv, ctm);
      if (!cur_busy) busy_ok = 1'b0;
      if (cur_fin) begin
        lat = e;
        break;
      end
      @(posedge clk);
    end
    g = cur_gcd;
    cyc = cur_cyc;
  endtask

  initial begin
    logic [31:0] g, av, bv, m;
    int          cyc, lat, wd, fins, accepts, next_acc, acc_edge, busy_bad, spurious;
    bit          busy_ok, ctm, running;
    logic [15:0] q[$];
    logic [15:0] p;

    tbl[0]  = '{0, 34, 12, 1'b0, 2, 8};
    tbl[1]  = '{0, 34, 12, 1'b1, 2, 17};
    tbl[2]  = '{0, 1, 1, 1'b1, 1, 17};
    tbl[3]  = '{1, 48, 18, 1'b0, 6, 7};
    tbl[4]  = '{1, 0, 0, 1'b0, 0, 1};
    tbl[5]  = '{1, 0, 255, 1'b0, 255, 1};
    tbl[6]  = '{0, 0, 0, 1'b1, 0, 17};
    tbl[7]  = '{0, 255, 255, 1'b0, 255, 2};
    tbl[8]  = '{2, 32'h8000_0000, 6, 1'b1, 2, 65};
    tbl[9]  = '{0, 1, 1, 1'b0, 1, 2};
    tbl[10] = '{0, 128, 64, 1'b0, 64, 9};

    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gcd8", g8, 0);
    check("rst_finish8", fin8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_cycles8", cyc8, 0);
    check("rst_busy16", busy16, 0);
    check("rst_cycles32", cyc32, 0);
    rst_n = 1'b1;

    // Directed vectors
    foreach (tbl[i]) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].ct, g, cyc, lat, busy_ok);
      check($sformatf("vec%0d_gcd", i), g, tbl[i].g);
      check($sformatf("vec%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].cyc);
      check($sformatf("vec%0d_busy", i), busy_ok, 1);
    end

    // start held high with changing operands: only IDLE samples are taken
    cur = 0;
    fins = 0; accepts = 0; next_acc = 0; acc_edge = 0; busy_bad = 0; running = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 34, 12, 1'b0);
    for (int n = 0; n < 300 && fins < 4; n++) begin
      @(posedge clk);
      if (n == next_acc) begin
        q.push_back({a8, b8});
        acc_edge = n;
        running = 1'b1;
        accepts++;
      end
      @(negedge clk);
      if (busy8 !== running) busy_bad++;
      if (fin8) begin
        fins++;
        if (!running || q.size() == 0) begin
          check("hold_spurious_finish", 1, 0);
        end else begin
          p = q.pop_front();
          check($sformatf("hold_gcd%0d", fins), g8, ref_gcd(p[15:8], p[7:0]));
          check($sformatf("hold_latency%0d", fins), n - acc_edge, cyc8);
        end
        running = 1'b0;
        next_acc = n + 2;
      end
      drive(0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
    end
    drive(0, 1'b0, 0, 0, 1'b0);
    check("hold_finish_count", fins, 4);
    check("hold_accepts_vs_finishes", accepts, fins);
    check("hold_busy_errors", busy_bad, 0);

    // Reset during RUN cycle 4 aborts the operation silently
    @(negedge clk);
    drive(0, 1'b1, 34, 12, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 34, 12, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_gcd", g8, 0);
    check("abort_finish", fin8, 0);
    check("abort_busy", busy8, 0);
    check("abort_cycles", cyc8, 0);
    rst_n = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(negedge clk);
      if (fin8) spurious++;
    end
    check("abort_no_finish", spurious, 0);
    run_op(0, 45, 75, 1'b0, g, cyc, lat, busy_ok);
    check("post_abort_gcd", g, 15);
    check("post_abort_latency", lat, cyc);

    // Random sweep at W=8 and W=32 against the Euclid model
    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 3; s += 2) begin
        wd = width_of(s);
        if (s == 0) begin
          if (i % 2 == 1) begin
            av = $urandom_range(0, 255);
            bv = $urandom_range(0, 255);
          end else begin
            m = $urandom_range(1, 15);
            av = $urandom_range(0, 17) * m;
            bv = $urandom_range(0, 17) * m;
          end
        end else begin
          if (i % 2 == 1) begin
            av = $urandom;
            bv = $urandom;
          end else begin
            m = $urandom_range(1, 4096);
            av = $urandom_range(0, 1 << 19) * m;
            bv = $urandom_range(0, 1 << 19) * m;
          end
        end
        if (i % 10 == 3) bv = 0;
        ctm = bit'($urandom_range(0, 1));
        run_op(s, av, bv, ctm, g, cyc, lat, busy_ok);
        check($sformatf("rnd%0d_w%0d_gcd a=%0d b=%0d", i, wd, av, bv), g, ref_gcd(av, bv));
        if (ctm) begin
          check($sformatf("rnd%0d_w%0d_ct_cycles", i, wd), cyc, 2 * wd + 1);
          check($sformatf("rnd%0d_w%0d_ct_latency", i, wd), lat, 2 * wd + 1);
        end else begin
          check($sformatf("rnd%0d_w%0d_var_bound", i, wd), (cyc >= 1 && cyc <= 2 * wd + 1), 1);
          check($sformatf("rnd%0d_w%0d_var_latency", i, wd), lat, cyc);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_gcd.md
# bin_gcd

Parametrised binary (Stein) GCD engine with start/finish handshake, the next generation of the team's 8-bit GCD unit. Adds generic operand width, a selectable constant-time mode (fixed latency independent of operand values, for side-channel hardening of the RSA key-setup path), a busy flag and a per-operation step count for timing-leakage measurement. Sits alongside the modular-exponentiation datapath; checks coprimality of e and φ(n).

## Interface
- W, 8: operand/result width in bits, ≥ 2
- CW, $clog2(2*W+2): width of `cycles`
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  request; sampled only in IDLE
- a  in  W  operand A, latched on accepted start
- b  in  W  operand B, latched on accepted start
- ct_mode  in  1  1 = constant-time; latched on accepted start
- gcd  out  W  result; valid from the finish cycle, held until next accepted start
- finish  out  1  one-cycle pulse, result valid
- busy  out  1  high in RUN and DONE
- cycles  out  CW  RUN cycles used by last operation; updated with gcd

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: busy=0. start=1 → x←a, y←b, k←0, it←0, ct←ct_mode, go RUN. start outside IDLE ignored (no queueing).
- RUN, one step per cycle, priority order:
  - term = (x==0)||(y==0).
  - Variable mode: term → result ←(x|y)<<k, cycles←it+1, go DONE.
  - Both even: x>>=1, y>>=1, k++.
  - x even: x>>=1. y even: y>>=1.
  - Both odd, x≥y: x←(x−y)>>1; else y←(y−x)>>1.
  - it increments every RUN cycle.
- CT mode: after term, x/y/k hold (dummy cycle, same register enables toggle pattern not required). Exit to DONE exactly when it==2W, i.e. RUN lasts 2W+1 cycles always; cycles←2W+1.
- Step bound: sum of bit lengths ≤ 2W, each non-terminal step reduces it by ≥1 → term reached within 2W steps; CT padding never truncates.
- Arithmetic: x, y unsigned W bits; subtraction never underflows (guarded by compare); k width $clog2(W+1); result shift cannot overflow W (gcd ≤ max(a,b)).
- Zero operands: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
- DONE: finish=1, busy=1, one cycle, then IDLE.

## Timing
- Reset (rst_n=0 at posedge): state IDLE, gcd=0, finish=0, busy=0, cycles=0; internal regs cleared. Reset mid-operation aborts with no finish pulse.
- Accept edge = cycle 0. RUN occupies cycles 1..N; finish high in cycle N+1; earliest next accept at the edge ending cycle N+2.
- Variable mode: N = reduction steps + 1. CT mode: N = 2W+1 (W=8: finish in cycle 18).
- gcd and cycles change only on the RUN→DONE edge and on reset.

## Structure
- Shared package rsa_pkg: state encoding (IDLE/RUN/DONE), helper constant functions for CW and k width.
- One sub-module, bin_gcd_step: combinational datapath (x, y, k in → next x, y, k, term out); top holds FSM, counter, output registers.
- Total RTL ≈ 150–250 lines.

## Test plan
- W=8, a=34, b=12, ct_mode=0 → finish in cycle 9, gcd=2, cycles=8.
- Same operands, ct_mode=1 → finish in cycle 18, gcd=2, cycles=17; repeat with a=1, b=1 → identical latency.
- W=16, a=48, b=18, ct_mode=0 → gcd=6, cycles=7; a=0, b=0 → gcd=0, cycles=1; a=0, b=255 → gcd=255.
- start held high continuously with changing a/b → only IDLE samples accepted; busy high throughout RUN/DONE; one finish per accept.
- rst_n low during RUN cycle 4 → next cycle all outputs 0, no finish pulse; fresh start afterwards correct.
- Random W=8 and W=32 sweep vs reference model: gcd matches, CT latency constant, variable cycles ≤ 2W+1.
